// File: rtl/lm_sm_seq.sv
// Load-multiple / store-multiple sequencer: moves the registers selected by
// reg_mask between the register file and consecutive memory words, one per cycle.
module lm_sm_seq #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        reg_mask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [2:0]        rf_raddr,
    output logic [2:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wen,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         mask_q, mask_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic               store_q, store_d;
    logic [2:0]         idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               rd_d, wr_d, wen_d, busy_d, done_d;
    logic [2:0]         raddr_d, waddr_d;
    logic [DATA_W-1:0]  wdata_d;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [2:0] low_bit(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Store data comes straight from the register-file read port.
    assign mem_wdata = rf_rdata;

    // Next-state and next-output logic; strobes are precomputed so they are glitch-free flops.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        k_d     = k_q;
        base_d  = base_q;
        store_d = store_q;
        addr_d  = mem_addr;
        idx_d   = 3'd0;
        rd_d    = 1'b1;
        wr_d    = 1'b1;
        raddr_d = 3'd0;
        wen_d   = 1'b0;
        waddr_d = rf_waddr;
        wdata_d = rf_wdata;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    mask_d  = reg_mask;
                    store_d = is_store;
                    k_d     = '0;
                    if (reg_mask != 8'd0) begin
                        state_d = XFER;
                        addr_d  = base_addr;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            XFER: begin
                mask_d = mask_q & ~(8'd1 << idx_q);
                k_d    = k_q + CNT_W'(1);
                if (!store_q) begin
                    wen_d   = 1'b1;
                    waddr_d = idx_q;
                    wdata_d = mem_rdata;
                end
                if (mask_d == 8'd0) begin
                    state_d = DONE;
                end else begin
                    addr_d = base_q + ADDR_W'(k_d);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == XFER) begin
            idx_d   = low_bit(mask_d);
            rd_d    = store_d;
            wr_d    = ~store_d;
            raddr_d = store_d ? idx_d : 3'd0;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!proc_rst) begin
            state_q   <= IDLE;
            mask_q    <= 8'd0;
            k_q       <= '0;
            base_q    <= '0;
            store_q   <= 1'b0;
            idx_q     <= 3'd0;
            mem_addr  <= '0;
            mem_read  <= 1'b1;
            mem_write <= 1'b1;
            rf_raddr  <= 3'd0;
            rf_waddr  <= 3'd0;
            rf_wdata  <= '0;
            rf_wen    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            k_q       <= k_d;
            base_q    <= base_d;
            store_q   <= store_d;
            idx_q     <= idx_d;
            mem_addr  <= addr_d;
            mem_read  <= rd_d;
            mem_write <= wr_d;
            rf_raddr  <= raddr_d;
            rf_waddr  <= waddr_d;
            rf_wdata  <= wdata_d;
            rf_wen    <= wen_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_lm_sm_seq.sv
// Directed bench for lm_sm_seq with a behavioural memory and register file.
module tb_lm_sm_seq;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              proc_rst, start, is_store;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        reg_mask;
    logic [DATA_W-1:0] mem_rdata, rf_rdata, mem_wdata, rf_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write, mem_read, rf_wen, busy, done;
    logic [2:0]        rf_raddr, rf_waddr;

    logic [DATA_W-1:0] mem [32];
    logic [DATA_W-1:0] rf  [8];
    logic              pre_mem_en = 1'b0, pre_rf_en = 1'b0;
    logic [4:0]        pre_idx = 5'd0;
    logic [DATA_W-1:0] pre_val = '0;

    int checks = 0, errors = 0;
    int wen_cnt = 0, strobe_cnt = 0, wr_cnt = 0;
    int s0, w0, r0;

    lm_sm_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .proc_rst(proc_rst), .start(start), .is_store(is_store),
        .base_addr(base_addr), .reg_mask(reg_mask), .mem_rdata(mem_rdata),
        .rf_rdata(rf_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .rf_raddr(rf_raddr),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign rf_rdata  = rf[rf_raddr];

    // Memory samples write strobe on the falling edge.
    always @(negedge clk) begin
        if (!mem_write) mem[mem_addr] <= mem_wdata;
        else if (pre_mem_en) mem[pre_idx] <= pre_val;
        if (!mem_read || !mem_write) strobe_cnt <= strobe_cnt + 1;
        if (!mem_write) wr_cnt <= wr_cnt + 1;
    end

    // Register file writes on the rising edge.
    always @(posedge clk) begin
        if (rf_wen) begin
            rf[rf_waddr] <= rf_wdata;
            wen_cnt      <= wen_cnt + 1;
        end else if (pre_rf_en) begin
            rf[pre_idx[2:0]] <= pre_val;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input logic is_mem, input int idx, input logic [DATA_W-1:0] val);
        pre_mem_en = is_mem;
        pre_rf_en  = ~is_mem;
        pre_idx    = 5'(idx);
        pre_val    = val;
        step();
        pre_mem_en = 1'b0;
        pre_rf_en  = 1'b0;
    endtask

    task automatic kick(input logic st, input logic [7:0] m, input logic [ADDR_W-1:0] b);
        is_store  = st;
        reg_mask  = m;
        base_addr = b;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    initial begin
        proc_rst = 1'b0; start = 1'b0; is_store = 1'b0;
        base_addr = '0; reg_mask = 8'd0;
        step(); step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd3);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wen", 32'(rf_wen), 32'd0);
        proc_rst = 1'b1;
        step();

        // Load R0, R2 from addresses 4, 5.
        for (int i = 0; i < 8; i++) preload(1'b0, i, '0);
        preload(1'b1, 4, 16'hAAAA);
        preload(1'b1, 5, 16'h5555);
        kick(1'b0, 8'b0000_0101, 5'd4);
        check("ld_t0_strb", {30'd0, mem_read, mem_write}, 32'd1);
        check("ld_t0_addr", 32'(mem_addr), 32'd4);
        check("ld_t0_busy", 32'(busy), 32'd1);
        step();
        check("ld_t1_addr", 32'(mem_addr), 32'd5);
        check("ld_t1_wen", {rf_wen, 12'd0, rf_waddr, rf_wdata}, {1'b1, 12'd0, 3'd0, 16'hAAAA});
        step();
        check("ld_done", 32'(done), 32'd1);
        check("ld_w2", {rf_wen, 12'd0, rf_waddr, rf_wdata}, {1'b1, 12'd0, 3'd2, 16'h5555});
        check("ld_dn_strb", {30'd0, mem_read, mem_write}, 32'd3);
        step();
        check("ld_idle", {30'd0, busy, done}, 32'd0);
        check("ld_r0", 32'(rf[0]), 32'hAAAA);
        check("ld_r2", 32'(rf[2]), 32'h5555);
        check("ld_r1", 32'(rf[1]), 32'd0);

        // Store all eight registers from base 30 with wraparound.
        for (int i = 0; i < 8; i++) preload(1'b0, i, DATA_W'(16'h1000 + i));
        w0 = wen_cnt;
        kick(1'b1, 8'hFF, 5'd30);
        for (int j = 0; j < 8; j++) begin
            check("st_strb", {30'd0, mem_read, mem_write}, 32'd2);
            check("st_addr", 32'(mem_addr), 32'((30 + j) % 32));
            check("st_raddr", 32'(rf_raddr), 32'(j));
            step();
        end
        check("st_done", 32'(done), 32'd1);
        check("st_m30", 32'(mem[30]), 32'h1000);
        check("st_m0", 32'(mem[0]), 32'h1002);
        check("st_m5", 32'(mem[5]), 32'h1007);
        check("st_nowen", 32'(wen_cnt - w0), 32'd0);
        step();

        // Empty mask completes immediately without strobes.
        s0 = strobe_cnt; w0 = wen_cnt;
        kick(1'b0, 8'h00, 5'd7);
        check("z_done", {30'd0, busy, done}, 32'd3);
        step();
        check("z_idle", {30'd0, busy, done}, 32'd0);
        check("z_strobes", 32'(strobe_cnt - s0), 32'd0);
        check("z_wen", 32'(wen_cnt - w0), 32'd0);

        // Reset during a five-register load after two transfers.
        for (int i = 0; i < 5; i++) preload(1'b0, i, '0);
        for (int i = 0; i < 5; i++) preload(1'b1, 10 + i, DATA_W'(16'hB000 + i));
        w0 = wen_cnt;
        kick(1'b0, 8'h1F, 5'd10);
        step();
        step();
        proc_rst = 1'b0;
        step();
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_strb", {30'd0, mem_read, mem_write}, 32'd3);
        check("rs_wen", 32'(rf_wen), 32'd0);
        proc_rst = 1'b1;
        s0 = strobe_cnt;
        step(); step(); step();
        check("rs_r0", 32'(rf[0]), 32'hB000);
        check("rs_r1", 32'(rf[1]), 32'hB001);
        check("rs_r2", 32'(rf[2]), 32'd0);
        check("rs_wcnt", 32'(wen_cnt - w0), 32'd2);
        check("rs_nostrb", 32'(strobe_cnt - s0), 32'd0);

        // Start held high through a three-register store and its DONE cycle.
        r0 = wr_cnt;
        is_store = 1'b1; reg_mask = 8'b0000_1110; base_addr = 5'd0;
        start = 1'b1;
        step();
        for (int j = 1; j <= 3; j++) begin
            check("hold_raddr", 32'(rf_raddr), 32'(j));
            step();
        end
        check("hold_done", 32'(done), 32'd1);
        step();
        check("hold_idle", 32'(busy), 32'd0);
        start = 1'b0;
        step();
        check("hold_still", 32'(busy), 32'd0);
        check("hold_wr", 32'(wr_cnt - r0), 32'd3);
        kick(1'b0, 8'h01, 5'd3);
        check("second_op", {30'd0, busy, mem_read}, 32'd2);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lm_sm_seq.md
LM_SM_SEQ -- requirements
Module: lm_sm_seq

Interface
REQ-001 Parameter ADDR_W, default 5, memory word-address width; addresses wrap modulo 2^ADDR_W.
REQ-002 Parameter DATA_W, default 16, memory and register-file data width.
REQ-003 The design SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  rising-edge system clock; the downstream memory samples strobes on the falling edge.
REQ-005 proc_rst  in  1  synchronous active-low reset, sampled on rising clk.
REQ-006 start  in  1  request pulse; sampled only in IDLE.
REQ-007 is_store  in  1  1 = store-multiple (RF to memory); 0 = load-multiple (memory to RF).
REQ-008 base_addr  in  ADDR_W  first memory address.
REQ-009 reg_mask  in  8  bit i set = transfer register Ri.
REQ-010 mem_rdata  in  DATA_W  memory read data; valid at the rising edge ending the read cycle.
REQ-011 rf_rdata  in  DATA_W  combinational register-file read data for rf_raddr.
REQ-012 mem_addr  out  ADDR_W  memory address.
REQ-013 mem_wdata  out  DATA_W  memory write data (= rf_rdata).
REQ-014 mem_write  out  1  active-low memory write strobe.
REQ-015 mem_read  out  1  active-low memory read strobe.
REQ-016 rf_raddr  out  3  register-file read index.
REQ-017 rf_waddr  out  3  register-file write index (registered).
REQ-018 rf_wdata  out  DATA_W  register-file write data (registered).
REQ-019 rf_wen  out  1  active-high register-file write enable (registered).
REQ-020 busy  out  1  high in XFER and DONE.
REQ-021 done  out  1  one-cycle completion pulse.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, XFER and DONE.
REQ-023 In IDLE, on start=1 the block SHALL latch base_addr, reg_mask and is_store, and clear the transfer count k.
- Nonzero mask: go to XFER.
- Zero mask: go to DONE.
REQ-024 start SHALL be ignored in XFER and DONE; there is no queuing.
REQ-025 In each XFER cycle the block SHALL perform one transfer:
- i = lowest set bit of the remaining mask.
- mem_addr = latched base + k, modulo 2^ADDR_W.
- Clear bit i of the remaining mask; increment k.
REQ-026 Store transfer: mem_write=0, rf_raddr=i, mem_wdata=rf_rdata, mem_read=1.
REQ-027 Load transfer: mem_read=0, mem_write=1; at the closing rising edge, rf_wdata<=mem_rdata, rf_waddr<=i and rf_wen<=1.
- Effect: the RF write for a load is visible in the following cycle.
REQ-028 rf_wen SHALL be high for exactly one cycle per load transfer and SHALL be 0 for stores.
REQ-029 After the transfer that empties the remaining mask, the FSM SHALL go to DONE.
- Load: the final rf_wen pulse coincides with DONE.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-031 Outside XFER: mem_read=1, mem_write=1, mem_addr holds its last value, rf_raddr=0.
REQ-032 Transfer count SHALL equal popcount(reg_mask), from 0 to 8 cycles; the XFER duration SHALL be popcount(reg_mask) cycles.
REQ-033 Addresses SHALL be consecutive and ascending, in the same order as ascending register index.

Reset
REQ-034 When proc_rst=0 at a rising edge, the block SHALL enter IDLE and set the following, regardless of current state:
- busy=0, done=0, rf_wen=0, rf_waddr=0, rf_wdata=0.
- mem_addr=0, internal mask and k cleared.
- mem_read=1, mem_write=1.
REQ-035 After a mid-transfer reset, no further strobes or RF writes SHALL occur; completed transfers are not rolled back.

Verification
REQ-036 Load, mask 8'b0000_0101, base 4, mem[4]=16'hAAAA, mem[5]=16'h5555 -> 2 read cycles at addr 4 then 5; rf writes R0=AAAA then R2=5555; done 3 cycles after start accepted.
REQ-037 Store, mask 8'hFF, base 30 -> 8 write cycles at addr 30,31,0,1,2,3,4,5 with rf_raddr 0..7; mem[30]=R0 and mem[5]=R7 afterwards.
REQ-038 Mask 8'h00 -> done=1 in the cycle after start; no strobe ever low; rf_wen stays 0.
REQ-039 Load, mask 8'h1F; proc_rst=0 after 2 transfers -> next cycle IDLE, strobes high, rf_wen=0; only R0 and R1 are written.
REQ-040 start held high through a 3-register store and its DONE cycle -> exactly one operation runs; a second operation begins only from IDLE.
